tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Sequential 1-to-8 time-division demultiplexer: receiving end of an 8-lane TDM link whose transmit side scans an 8:1 mux select through slots 0..7. It samples one lane-word per valid beat, steers it into the lane addressed by an internal slot counter, and presents the completed 8-lane frame as a registered parallel word with a one-cycle `frame_valid` strobe. It sits between the serial link and the parallel consumer logic.

## Interface
- `WIDTH`, default 1: bits per lane word; frame output is 8*`WIDTH` bits.
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `EN`  in  1  block enable; low freezes all state, no sampling.
- `din`  in  `WIDTH`  incoming lane word.
- `din_valid`  in  1  `din` carries a valid beat this cycle.
- `sync`  in  1  frame-start marker; qualified by `din_valid`, marks the beat as slot 0.
- `Y`  out  8*`WIDTH`  last completed frame; lane k at bits [k*WIDTH +: WIDTH].
- `frame_valid`  out  1  one-cycle pulse: `Y` updated this cycle.
- `slot`  out  3  slot index the next beat will be written to.
- `busy`  out  1  high while in RUN.
- `sync_err`  out  1  one-cycle pulse: sync arrived at a slot other than 0.

## Operation
- States: IDLE (waiting for first sync), RUN (collecting beats).
- Accepted beat = `EN && din_valid && (state==RUN || sync)`. Beats with `din_valid` in IDLE without `sync` are dropped.
- IDLE -> RUN on accepted sync beat: `din` written to shadow lane 0, `slot` becomes 1.
- RUN, accepted beat without sync: `din` written to shadow lane `slot`, `slot` increments modulo 8.
- Beat in slot 7: shadow lanes 0..6 plus this beat are copied to `Y` on the same edge; `frame_valid` high in the following cycle; `slot` wraps to 0, state stays RUN (continuous TDM, no re-sync needed).
- Sync in RUN while `slot==0`: normal slot-0 beat, no error.
- Sync in RUN while `slot!=0`: `sync_err` pulses, partial frame discarded (shadow cleared), beat written as lane 0, `slot` becomes 1. No `frame_valid` for the aborted frame.
- `EN` low: `slot`, state, shadow and `Y` hold; `frame_valid`, `sync_err` forced 0.
- `Y` holds its value until the next completed frame.
- Reset (any time, including mid-frame): state IDLE, `slot`=0, shadow=0, `Y`=0, `frame_valid`=0, `sync_err`=0, `busy`=0. Partial frame is lost.

## Timing
- Beats sampled on rising `clk`; one beat per cycle maximum, back-to-back allowed.
- Latency: slot-7 beat sampled at edge N -> `Y` and `frame_valid` valid after edge N, `frame_valid` deasserts after edge N+1 unless another frame completes (impossible before 8 beats, except `WIDTH` irrelevant).
- Minimum frame period: 8 cycles; consecutive `frame_valid` pulses at least 8 cycles apart.
- `sync_err` asserted the cycle after the offending edge, for exactly one cycle.
- All outputs registered; no combinational path input -> output.
- `slot` and `busy` reflect state after the most recent edge.

## Structure
- Shared package/header `tdm_pkg`: `NUM_SLOTS`=8, `SLOT_W`=3, state encodings `S_IDLE`, `S_RUN`.
- Sub-module `slot_decoder`: 3-to-8 one-hot decoder with enable, producing per-lane write strobes from `slot` and the accepted-beat signal; instantiated once.
- Top holds FSM, slot counter, shadow register bank, output register and pulse flags.

## Test plan
- Reset then sync+8 beats `din`=1,0,1,1,0,0,1,0 (WIDTH=1) -> one `frame_valid` pulse, `Y`=8'b0100_1101, `slot`=0, `busy`=1.
- Two frames back-to-back without second sync, patterns 0xA5 then 0x3C -> `frame_valid` pulses exactly 8 cycles apart, `Y`=0xA5 then 0x3C.
- Sync at slot 3 -> `sync_err` one pulse, no `frame_valid`, next 7 beats complete a frame with the resync beat as lane 0.
- `EN` low for 5 cycles mid-frame with `din_valid` toggling -> `slot` frozen, no writes; frame completes correctly after re-enable.
- `din_valid` beats in IDLE without sync -> ignored, `slot`=0, `busy`=0, `Y` unchanged.
- `rst_n` asserted at slot 5 -> all outputs 0 immediately (asynchronously); subsequent sync-led frame 0xFF completes normally.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and types for the 8-lane TDM receive path.
package tdm_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    // Two-state receive FSM: waiting for the first sync, then collecting beats.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } tdm_state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    // Slot counter advance; the width wraps 7 -> 0 naturally.
    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/slot_decoder.sv
// 3-to-8 one-hot decoder: turns the target slot index and the accepted-beat
// qualifier into per-lane write strobes for the shadow register bank.
module slot_decoder
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0]    i_sel,
    input  logic                 i_en,
    output logic [NUM_SLOTS-1:0] o_strobe
);

    // At most one strobe is high, and only when a beat is being accepted.
    always_comb begin
        o_strobe = '0;
        if (i_en) begin
            o_strobe[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// Sequential 1-to-8 TDM demultiplexer. One lane word is accepted per valid
// beat and steered into the shadow lane addressed by the slot counter; when
// the slot-7 beat arrives the full frame is copied to Y and frame_valid pulses.
//
// Handshake: there is no back-pressure. A beat is taken on a rising edge when
// EN && din_valid && (state is RUN || sync); otherwise din is ignored.
// frame_valid and sync_err are single-cycle pulses seen after the edge that
// caused them. busy is the FSM state (high in RUN) and doubles as its debug view.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       EN,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    input  logic                       sync,
    output logic [NUM_SLOTS*WIDTH-1:0] Y,
    output logic                       frame_valid,
    output logic [SLOT_W-1:0]          slot,
    output logic                       busy,
    output logic                       sync_err
);

    tdm_state_t                 r_state;
    logic [SLOT_W-1:0]          r_slot;
    logic                       r_busy;
    logic                       r_frame_valid;
    logic                       r_sync_err;
    logic [NUM_SLOTS*WIDTH-1:0] r_shadow;
    logic [NUM_SLOTS*WIDTH-1:0] r_y;

    logic                       w_accept;
    logic                       w_resync;
    logic                       w_complete;
    logic [SLOT_W-1:0]          w_wr_slot;
    logic [NUM_SLOTS-1:0]       w_strobe;

    // Beat qualification. A sync beat always targets lane 0; a sync that lands
    // mid-frame aborts the partial frame. A frame completes only on a plain
    // (non-sync) beat in slot 7, so an aborting sync can never complete one.
    always_comb begin
        w_accept   = EN && din_valid && ((r_state == S_RUN) || sync);
        w_resync   = w_accept && sync && (r_state == S_RUN) && (r_slot != '0);
        w_complete = w_accept && !sync && (r_state == S_RUN) && (r_slot == LAST_SLOT);
        w_wr_slot  = sync ? '0 : r_slot;
    end

    slot_decoder u_slot_decoder (
        .i_sel    (w_wr_slot),
        .i_en     (w_accept),
        .o_strobe (w_strobe)
    );

    // FSM, slot counter and the one-cycle pulse flags. Pulses default low every
    // cycle, which also forces them to 0 while EN is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_slot        <= '0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        // Only a sync beat is accepted here; it fills lane 0.
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_slot  <= SLOT_W'(1);
                    end
                    S_RUN: begin
                        if (sync) begin
                            r_slot     <= SLOT_W'(1);
                            r_sync_err <= w_resync;
                        end else begin
                            r_slot        <= next_slot(r_slot);
                            r_frame_valid <= w_complete;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_slot  <= '0;
                    end
                endcase
            end
        end
    end

    // Shadow lane bank and output frame register. A mid-frame sync clears the
    // shadow so no stale lanes from the aborted frame survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_y      <= '0;
        end else begin
            if (w_resync) begin
                r_shadow            <= '0;
                r_shadow[0 +: WIDTH] <= din;
            end else begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (w_strobe[k]) begin
                        r_shadow[k*WIDTH +: WIDTH] <= din;
                    end
                end
            end
            if (w_complete) begin
                r_y <= {din, r_shadow[(NUM_SLOTS-1)*WIDTH-1:0]};
            end
        end
    end

    assign Y           = r_y;
    assign frame_valid = r_frame_valid;
    assign slot        = r_slot;
    assign busy        = r_busy;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 (WIDTH=1): a cycle-by-cycle vector table for
// continuous frames and resync, plus hand sequences for EN freeze, idle
// filtering and asynchronous reset.
module tb_tdm_demux8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [0:0] din;
    logic       din_valid;
    logic       sync;
    logic [7:0] y;
    logic       frame_valid;
    logic [2:0] slot;
    logic       busy;
    logic       sync_err;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       en;
        logic       dv;
        logic       sy;
        logic       din;
        logic [7:0] y;
        logic       fv;
        logic [2:0] slot;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    tdm_demux8 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .EN          (en),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .Y           (y),
        .frame_valid (frame_valid),
        .slot        (slot),
        .busy        (busy),
        .sync_err    (sync_err)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ey, input logic efv,
                             input logic [2:0] eslot, input logic ebusy, input logic eerr);
        check({tag, ".Y"}, y, ey);
        check({tag, ".frame_valid"}, {7'd0, frame_valid}, {7'd0, efv});
        check({tag, ".slot"}, {5'd0, slot}, {5'd0, eslot});
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, ebusy});
        check({tag, ".sync_err"}, {7'd0, sync_err}, {7'd0, eerr});
    endtask

    // Driver: present inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic e, input logic dv, input logic sy, input logic d);
        @(negedge clk);
        en        = e;
        din_valid = dv;
        sync      = sy;
        din[0]    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic dv, input logic sy, input logic d,
                       input logic [7:0] ey, input logic efv, input logic [2:0] es,
                       input logic eb, input logic eerr);
        vec_t v;
        v.en = e; v.dv = dv; v.sy = sy; v.din = d;
        v.y = ey; v.fv = efv; v.slot = es; v.busy = eb; v.err = eerr;
        vecs.push_back(v);
    endtask

    // One full 8-beat frame: beat k carries bit k of pat. Y switches to pat and
    // frame_valid pulses only on the slot-7 row.
    task automatic add_frame(input logic [7:0] pat, input logic [7:0] y_prev,
                             input logic sync_first, input logic err_first);
        for (int k = 0; k < 8; k++) begin
            add(1'b1, 1'b1, (k == 0) && sync_first, pat[k],
                (k == 7) ? pat : y_prev, k == 7, 3'((k + 1) % 8), 1'b1,
                (k == 0) && err_first);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;

        // Vector table
        // Idle beat without sync is dropped.
        add(1, 1, 0, 1, 8'h00, 0, 3'd0, 0, 0);
        // Sync-led frame 1,0,1,1,0,0,1,0 -> 0x4D.
        add_frame(8'h4D, 8'h00, 1'b1, 1'b0);
        // Back-to-back frames with no further sync.
        add_frame(8'hA5, 8'h4D, 1'b0, 1'b0);
        add_frame(8'h3C, 8'hA5, 1'b0, 1'b0);
        // Three beats of a partial frame, then a sync at slot 3.
        add(1, 1, 0, 1, 8'h3C, 0, 3'd1, 1, 0);
        add(1, 1, 0, 1, 8'h3C, 0, 3'd2, 1, 0);
        add(1, 1, 0, 1, 8'h3C, 0, 3'd3, 1, 0);
        // Resync beat is lane 0 (0), then 7 beats complete 0xB2.
        add_frame(8'hB2, 8'h3C, 1'b1, 1'b1);
        // Sync exactly at slot 0 in RUN: no error.
        add_frame(8'h5A, 8'hB2, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        check_all("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].dv, vecs[i].sy, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].y, vecs[i].fv,
                      vecs[i].slot, vecs[i].busy, vecs[i].err);
        end

        // EN low mid-frame: pattern 0x96, three beats then a 5-cycle freeze.
        step(1, 1, 0, 1'b0);
        step(1, 1, 0, 1'b1);
        step(1, 1, 0, 1'b1);
        check("en.slot_before", {5'd0, slot}, 8'd3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i[0] == 1'b0, i == 2, 1'b1);
            check_all($sformatf("en_off%0d", i), 8'h5A, 1'b0, 3'd3, 1'b1, 1'b0);
        end
        step(1, 1, 0, 1'b0);
        step(1, 1, 0, 1'b1);
        step(1, 1, 0, 1'b0);
        step(1, 1, 0, 1'b0);
        check_all("en_slot6", 8'h5A, 1'b0, 3'd7, 1'b1, 1'b0);
        step(1, 1, 0, 1'b1);
        check_all("en_done", 8'h96, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1, 0, 0, 1'b0);
        check("en.fv_drop", {7'd0, frame_valid}, 8'd0);

        // Idle filtering after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 1'b1);
            check_all($sformatf("idle%0d", i), 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        end
        // A frame so Y is nonzero, then sync an idle-led frame 0xC3.
        for (int k = 0; k < 8; k++) step(1, 1, k == 0, 8'hC3 >> k);
        check_all("c3", 8'hC3, 1'b1, 3'd0, 1'b1, 1'b0);
        // Idle beats after a frame are normal RUN beats, so no idle check here.

        // Asynchronous reset at slot 5.
        for (int k = 0; k < 5; k++) step(1, 1, 1'b0, 1'b1);
        check("ar.slot_before", {5'd0, slot}, 8'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step(1, 1, k == 0, 1'b1);
        check_all("ff", 8'hFF, 1'b1, 3'd0, 1'b1, 1'b0);
        step(0, 0, 0, 1'b0);
        check_all("ff_hold", 8'hFF, 1'b0, 3'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
